softmax_seq_ctrl: RTL
=====================

// Module: softmax_seq_ctrl
// PURPOSE
//  Sequential controller for the softmax stage of block-temperature inference. Accepts one packed logit
//  vector and drives a shared synchronous exp-LUT read port and a shared multi-cycle divider, one row at a time.
//  Returns the packed normalised vector through a valid/ready handshake.
//  Replaces the fully combinational per-row LUT/divide array when area matters.
// PARAMETERS
//  DATAWIDTH  11  bits per logit and per output element (two's complement in, unsigned out)
//  ROWS       10  elements per vector
//  LUT_WIDTH  22  exp-LUT word width
// PORTS
//  clk        in   1                   single clock, rising edge
//  rst_n      in   1                   asynchronous active-low reset
//  in_valid   in   1                   logit vector valid
//  in_ready   out  1                   controller can accept a vector
//  in_data    in   ROWS*DATAWIDTH      packed logits; row m = in_data[(ROWS-m-1)*DATAWIDTH +: DATAWIDTH]
//  lut_addr   out  DATAWIDTH           LUT address = raw logit bits (negative logits index the upper half)
//  lut_rd     out  1                   LUT read strobe; lut_data valid exactly 1 cycle later
//  lut_data   in   LUT_WIDTH           exp value
//  div_start  out  1                   1-cycle pulse launching a divide
//  div_num    out  LUT_WIDTH+DATAWIDTH numerator = exp[m] << DATAWIDTH (zero-extended)
//  div_den    out  LUT_WIDTH+5         denominator = fixed-up sum; div_num/div_den held stable until div_done
//  div_done   in   1                   1-cycle pulse, quotient valid; any latency >= 1 cycle
//  div_quot   in   LUT_WIDTH+DATAWIDTH quotient
//  out_valid  out  1                   result vector valid
//  out_ready  in   1                   downstream accepts
//  out_data   out  ROWS*DATAWIDTH      packed result, same row ordering as in_data
//  sat_flag   out  1                   sum saturated for the vector currently held in out_data
//  busy       out  1                   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE. in_ready=1. All other outputs 0, including out_data, exp buffer and sum.
//  FSM IDLE -> LOOKUP -> FIXUP -> DIV_ISSUE <-> DIV_WAIT -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready, register in_data, clear sum, go to LOOKUP. in_ready=0 outside IDLE.
//  LOOKUP: runs ROWS+1 cycles.
//   - Cycle k<ROWS: lut_rd=1, lut_addr=row k.
//   - Cycle k>=1: capture lut_data into exp[k-1] and add it into a LUT_WIDTH+5-bit sum (no wrap possible for ROWS<=32).
//  FIXUP (1 cycle):
//   - sum==0 -> sum=1.
//   - Else if sum[LUT_WIDTH+4]=1 -> sum={1'b0,{(LUT_WIDTH+4){1'b1}}} and sat_flag register set.
//  DIV_ISSUE (1 cycle): div_start=1 for row m (m from 0), drive div_num/div_den, then go to DIV_WAIT.
//  DIV_WAIT: hold div_num/div_den until div_done.
//   - On div_done: out_data row m = div_quot[LUT_WIDTH-1 -: DATAWIDTH].
//   - m==ROWS-1 -> DONE; else m++ -> DIV_ISSUE.
//   - div_done outside DIV_WAIT is ignored.
//  DONE: out_valid=1; out_data and sat_flag stable. On out_ready -> IDLE, out_valid=0 next cycle.
//   out_data keeps its last value until overwritten; sat_flag clears on the next accept.
//  Latency (accept to out_valid) = ROWS+1 + 1 + sum over rows of (1 + divider latency) + 1 cycles.
//  No new vector is accepted before the previous result handshakes; there is no overlap between vectors.
//  rst_n low in any state: immediate return to reset values. An in-flight divide is abandoned (div_start stays 0).
// TESTING
//  1 LUT model returns 0 everywhere, any logits -> sum fixed to 1, all out rows 0, sat_flag=0.
//  2 LUT[row0 addr]=4194303, others 0 -> div_den=4194303, row0 quotient=2048, out row0=1, others 0.
//  3 ROWS=20, LUT=4194303 everywhere -> raw sum 83886060 saturates to 67108863, sat_flag=1, each quotient=127, out=0.
//  4 Divider latency 1 then 7 cycles alternating; logits -1 (addr 2047) and 5 -> lut_addr sequence correct,
//    div_num/div_den stable while waiting, result identical to a golden model.
//  5 Hold out_ready=0 for 5 cycles in DONE -> out_valid/out_data/sat_flag stable, in_ready=0,
//    in_valid pulses ignored.
//  6 Assert rst_n low mid DIV_WAIT (row 3) -> outputs at reset values immediately; next vector processes correctly.

Source files
------------

// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - sequential softmax controller sharing one exp-LUT read port and one divider
//
// Takes one packed logit vector, looks every row up in an external synchronous
// exp-LUT, accumulates the exponentials, then normalises each row through an
// external multi-cycle divider. The normalised vector is returned through a
// valid/ready handshake. Only one vector is in flight at a time.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready     logit vector handshake
//   in_data               packed logits, row m at [(ROWS-m-1)*DATAWIDTH +: DATAWIDTH]
//   lut_addr/lut_rd       exp-LUT read request (data returns one cycle later)
//   lut_data              exp-LUT read data
//   div_start             one-cycle pulse launching a divide
//   div_num/div_den       divide operands, held stable until div_done
//   div_done/div_quot     divide completion pulse and quotient
//   out_valid/out_ready   result vector handshake
//   out_data              packed normalised result, same row ordering as in_data
//   sat_flag              the held result was normalised by a saturated sum
//   busy                  controller is not idle

module softmax_seq_ctrl #(
    parameter int DATAWIDTH = 11,
    parameter int ROWS      = 10,
    parameter int LUT_WIDTH = 22
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROWS*DATAWIDTH-1:0]      in_data,
    output logic [DATAWIDTH-1:0]           lut_addr,
    output logic                           lut_rd,
    input  logic [LUT_WIDTH-1:0]           lut_data,
    output logic                           div_start,
    output logic [LUT_WIDTH+DATAWIDTH-1:0] div_num,
    output logic [LUT_WIDTH+4:0]           div_den,
    input  logic                           div_done,
    input  logic [LUT_WIDTH+DATAWIDTH-1:0] div_quot,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ROWS*DATAWIDTH-1:0]      out_data,
    output logic                           sat_flag,
    output logic                           busy
);

    localparam int SW = LUT_WIDTH + 5;        // sum width
    localparam int NW = LUT_WIDTH + DATAWIDTH; // numerator / quotient width
    localparam int CW = $clog2(ROWS + 1);     // row counter must reach ROWS in LOOKUP

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FIXUP,
        S_DIV_ISSUE,
        S_DIV_WAIT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          idx;
    logic [CW-1:0]          idx_inc;
    logic [SW-1:0]          sum_q;
    logic [SW-1:0]          sum_fix;
    logic                   sat_next;
    logic [DATAWIDTH-1:0]   in_rows  [ROWS];
    logic [DATAWIDTH-1:0]   logit_q  [ROWS];
    logic [LUT_WIDTH-1:0]   exp_q    [ROWS];
    logic [DATAWIDTH-1:0]   out_q    [ROWS];
    logic                   unused_quot;

    // Row m lives at the top end of the packed bus, so row 0 is the MSB slice.
    for (genvar g = 0; g < ROWS; g++) begin : g_rows
        assign in_rows[g] = in_data[(ROWS-g-1)*DATAWIDTH +: DATAWIDTH];
        assign out_data[(ROWS-g-1)*DATAWIDTH +: DATAWIDTH] = out_q[g];
    end

    assign idx_inc = idx + CW'(1);

    // Only the integer-plus-fraction window of the quotient is kept.
    assign unused_quot = ^{div_quot[NW-1:LUT_WIDTH], div_quot[LUT_WIDTH-DATAWIDTH-1:0]};

    // A zero sum would make every divide undefined, so it is forced to 1.
    // A sum reaching the top bit is clamped so the divisor stays in range.
    always_comb begin
        sum_fix  = sum_q;
        sat_next = 1'b0;
        if (sum_q == '0) begin
            sum_fix = SW'(1);
        end else if (sum_q[SW-1]) begin
            sum_fix  = {1'b0, {(SW-1){1'b1}}};
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            sum_q     <= '0;
            in_ready  <= 1'b1;
            lut_addr  <= '0;
            lut_rd    <= 1'b0;
            div_start <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                logit_q[i] <= '0;
                exp_q[i]   <= '0;
                out_q[i]   <= '0;
            end
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        logit_q  <= in_rows;
                        sum_q    <= '0;
                        sat_flag <= 1'b0;
                        idx      <= '0;
                        lut_rd   <= 1'b1;
                        lut_addr <= in_rows[0];
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOOKUP;
                    end
                end

                // Cycle idx issues the read for row idx and captures the
                // data requested in cycle idx-1; one extra cycle drains.
                S_LOOKUP: begin
                    if (idx != '0) begin
                        exp_q[idx - CW'(1)] <= lut_data;
                        sum_q               <= sum_q + SW'(lut_data);
                    end
                    if (idx < CW'(ROWS - 1)) begin
                        lut_rd   <= 1'b1;
                        lut_addr <= logit_q[idx_inc];
                    end else begin
                        lut_rd <= 1'b0;
                    end
                    if (idx == CW'(ROWS)) begin
                        idx   <= '0;
                        state <= S_FIXUP;
                    end else begin
                        idx <= idx_inc;
                    end
                end

                // Operands for row 0 are loaded together with the pulse so
                // they are already valid in the cycle div_start is high.
                S_FIXUP: begin
                    sum_q     <= sum_fix;
                    sat_flag  <= sat_next;
                    div_num   <= {exp_q[0], {DATAWIDTH{1'b0}}};
                    div_den   <= sum_fix;
                    div_start <= 1'b1;
                    idx       <= '0;
                    state     <= S_DIV_ISSUE;
                end

                S_DIV_ISSUE: begin
                    state <= S_DIV_WAIT;
                end

                S_DIV_WAIT: begin
                    if (div_done) begin
                        out_q[idx] <= div_quot[LUT_WIDTH-1 -: DATAWIDTH];
                        if (idx == CW'(ROWS - 1)) begin
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            idx       <= idx_inc;
                            div_num   <= {exp_q[idx_inc], {DATAWIDTH{1'b0}}};
                            div_start <= 1'b1;
                            state     <= S_DIV_ISSUE;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
